// File: rtl/gamepad_pkg.sv
// Shared constants and types for the multi-pad Mega Drive scanner.
// GAMEPAD_SIX_BUTTON_EN selects the 8-phase six-button sequence; otherwise 2 phases.
package gamepad_pkg;

    localparam int NUM_BUTTONS  = 12;
    localparam int PINS_PER_PAD = 6;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    // Position of each connector pin inside a pad's 6-bit slice.
    localparam int PIN1 = 0;
    localparam int PIN2 = 1;
    localparam int PIN3 = 2;
    localparam int PIN4 = 3;
    localparam int PIN6 = 4;
    localparam int PIN9 = 5;

`ifdef GAMEPAD_SIX_BUTTON_EN
    localparam int PHASE_W = 3;
`else
    localparam int PHASE_W = 1;
`endif

    typedef logic [PHASE_W-1:0] phase_cnt_t;
    localparam phase_cnt_t LAST_PHASE = '1;

    typedef enum logic [2:0] {
        PH_0, PH_1, PH_2, PH_3, PH_4, PH_5, PH_6, PH_7
    } gamepad_phase_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/gamepad_pad_decode.sv
// Per-pad shadow capture, presence/type detection and frame commit with press edges.
// Six-button decode is only built when GAMEPAD_SIX_BUTTON_EN is defined.
module gamepad_pad_decode
    import gamepad_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample,
    input  logic                    commit,
    input  gamepad_phase_e          phase,
    input  logic [PINS_PER_PAD-1:0] pins,
    output logic [NUM_BUTTONS-1:0]  buttons,
    output logic [NUM_BUTTONS-1:0]  pressed,
    output logic                    present,
    output logic                    is6
);

    logic [7:0]             sh_btn, btn_next;
    logic                   sh_present, present_next;
    logic [3:0]             hi_word;
    logic                   six_word;
    logic [NUM_BUTTONS-1:0] word;

`ifdef GAMEPAD_SIX_BUTTON_EN
    logic [3:0] sh_ext, ext_next;
    logic       sh_id6, id6_next;
`endif

    // The last phase's sample and the commit share an edge, so commit uses the *_next view.
    always_comb begin
        btn_next     = sh_btn;
        present_next = sh_present;
`ifdef GAMEPAD_SIX_BUTTON_EN
        ext_next     = sh_ext;
        id6_next     = sh_id6;
`endif
        if (sample) begin
            case (phase)
                PH_0: begin
                    btn_next[BTN_UP]    = ~pins[PIN1];
                    btn_next[BTN_DOWN]  = ~pins[PIN2];
                    btn_next[BTN_LEFT]  = ~pins[PIN3];
                    btn_next[BTN_RIGHT] = ~pins[PIN4];
                    btn_next[BTN_B]     = ~pins[PIN6];
                    btn_next[BTN_C]     = ~pins[PIN9];
                end
                PH_1: begin
                    btn_next[BTN_A]     = ~pins[PIN6];
                    btn_next[BTN_START] = ~pins[PIN9];
                    present_next        = ~pins[PIN3] & ~pins[PIN4];
                end
`ifdef GAMEPAD_SIX_BUTTON_EN
                PH_5: id6_next = ~|pins[PIN4:PIN1];
                PH_6: begin
                    ext_next[BTN_X - BTN_X]    = ~pins[PIN3];
                    ext_next[BTN_Y - BTN_X]    = ~pins[PIN2];
                    ext_next[BTN_Z - BTN_X]    = ~pins[PIN1];
                    ext_next[BTN_MODE - BTN_X] = ~pins[PIN4];
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
`ifdef GAMEPAD_SIX_BUTTON_EN
        six_word = present_next & id6_next;
        hi_word  = six_word ? ext_next : '0;
`else
        six_word = 1'b0;
        hi_word  = '0;
`endif
        word = present_next ? {hi_word, btn_next} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_btn     <= '0;
            sh_present <= 1'b0;
`ifdef GAMEPAD_SIX_BUTTON_EN
            sh_ext     <= '0;
            sh_id6     <= 1'b0;
`endif
            buttons    <= '0;
            pressed    <= '0;
            present    <= 1'b0;
            is6        <= 1'b0;
        end else begin
            sh_btn     <= btn_next;
            sh_present <= present_next;
`ifdef GAMEPAD_SIX_BUTTON_EN
            sh_ext     <= ext_next;
            sh_id6     <= id6_next;
`endif
            pressed    <= '0;
            if (commit) begin
                buttons <= word;
                pressed <= word & ~buttons;
                present <= present_next;
                is6     <= six_word;
            end
        end
    end

endmodule

// File: rtl/gamepad_scanner.sv
// Frame-triggered parallel scanner for N_PADS Mega Drive pads.
// Define GAMEPAD_SIX_BUTTON_EN for the 8-phase six-button sequence.
module gamepad_scanner
    import gamepad_pkg::*;
#(
    parameter int N_PADS        = 2,
    parameter int SETTLE_CYCLES = 50
) (
    input  logic                            Clock50,
    input  logic                            Reset,
    input  logic                            v_sync,
    input  logic [PINS_PER_PAD*N_PADS-1:0]  Pinos,
    output logic [N_PADS-1:0]               Select,
    output logic [NUM_BUTTONS*N_PADS-1:0]   Saidas,
    output logic [NUM_BUTTONS*N_PADS-1:0]   Pressed,
    output logic [N_PADS-1:0]               Present,
    output logic [N_PADS-1:0]               Is6,
    output logic                            Valid,
    output logic                            Busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES);

    logic [2:0]                      vs_q;
    logic [PINS_PER_PAD*N_PADS-1:0]  pin_meta, pin_sync;
    logic                            vs_rise;
    scan_state_e                     state, state_next;
    logic [CNT_W-1:0]                cnt;
    phase_cnt_t                      phase;
    gamepad_phase_e                  phase_e;
    logic                            last_cycle, sample, commit;

    always_ff @(posedge Clock50) begin
        if (Reset) begin
            vs_q     <= '0;
            pin_meta <= '1;
            pin_sync <= '1;
        end else begin
            vs_q     <= {vs_q[1:0], v_sync};
            pin_meta <= Pinos;
            pin_sync <= pin_meta;
        end
    end

    assign vs_rise    = vs_q[1] & ~vs_q[2];
    assign last_cycle = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign sample     = (state == ST_SCAN) && last_cycle;
    assign commit     = sample && (phase == LAST_PHASE);
    assign phase_e    = gamepad_phase_e'(3'(phase));

    always_ff @(posedge Clock50) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (vs_rise) state_next = ST_SCAN;
            ST_SCAN: if (commit)  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Select = '1;
        Busy   = 1'b0;
        Valid  = 1'b0;
        if (state == ST_SCAN) begin
            Select = {N_PADS{~phase[0]}};
            Busy   = 1'b1;
        end
        if (state == ST_DONE) Valid = 1'b1;
    end

    always_ff @(posedge Clock50) begin
        if (Reset || state != ST_SCAN) begin
            cnt   <= '0;
            phase <= '0;
        end else if (last_cycle) begin
            cnt   <= '0;
            phase <= phase + 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        gamepad_pad_decode u_decode (
            .clk     (Clock50),
            .rst     (Reset),
            .sample  (sample),
            .commit  (commit),
            .phase   (phase_e),
            .pins    (pin_sync[PINS_PER_PAD*p +: PINS_PER_PAD]),
            .buttons (Saidas[NUM_BUTTONS*p +: NUM_BUTTONS]),
            .pressed (Pressed[NUM_BUTTONS*p +: NUM_BUTTONS]),
            .present (Present[p]),
            .is6     (Is6[p])
        );
    end

endmodule

// File: tb/tb_gamepad_scanner.sv
// Directed bench for gamepad_scanner with a Select-driven pad model.
// Expectations follow GAMEPAD_SIX_BUTTON_EN when defined.
module tb_gamepad_scanner;

    localparam int N  = 2;
    localparam int SC = 4;
`ifdef GAMEPAD_SIX_BUTTON_EN
    localparam int NPH    = 8;
    localparam int RST_PH = 3;
    localparam logic [11:0] EXP_X_START = 12'h180;
    localparam logic [1:0]  EXP_IS6     = 2'b01;
`else
    localparam int NPH    = 2;
    localparam int RST_PH = 1;
    localparam logic [11:0] EXP_X_START = 12'h080;
    localparam logic [1:0]  EXP_IS6     = 2'b00;
`endif
    localparam int LAT = 3 + NPH * SC;

    logic              Clock50 = 1'b0;
    logic              Reset   = 1'b1;
    logic              v_sync  = 1'b0;
    logic [6*N-1:0]    Pinos;
    logic [N-1:0]      Select, Present, Is6;
    logic [12*N-1:0]   Saidas, Pressed;
    logic              Valid, Busy;

    logic [1:0]        pres = 2'b01;
    logic [1:0]        six  = 2'b00;
    logic [1:0][11:0]  held;
    int                nlow = 0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] cap_saidas, cap_pressed;
    logic [1:0]  cap_present, cap_is6;
    int          lat;

    gamepad_scanner #(.N_PADS(N), .SETTLE_CYCLES(SC)) dut (
        .Clock50 (Clock50),
        .Reset   (Reset),
        .v_sync  (v_sync),
        .Pinos   (Pinos),
        .Select  (Select),
        .Saidas  (Saidas),
        .Pressed (Pressed),
        .Present (Present),
        .Is6     (Is6),
        .Valid   (Valid),
        .Busy    (Busy)
    );

    always #10 Clock50 = ~Clock50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Low-pulse counter: a real six-button pad tracks Select falling edges within a frame.
    always @(posedge Busy or negedge Select[0]) begin
        if (Busy && Select[0]) nlow = 0;
        else                   nlow = nlow + 1;
    end

    function automatic logic [5:0] pad_pins(input logic p, input logic s6,
                                            input logic [11:0] b, input logic sel, input int nl);
        if (!p) return 6'h3F;
        if (sel) begin
            if (s6 && nl == 3) return {~b[6], ~b[5], ~b[11], ~b[8], ~b[9], ~b[10]};
            return {~b[6], ~b[5], ~b[3], ~b[2], ~b[1], ~b[0]};
        end
        if (s6 && nl == 3) return {~b[7], ~b[4], 4'b0000};
        if (s6 && nl == 4) return {~b[7], ~b[4], 4'b1111};
        return {~b[7], ~b[4], 2'b00, ~b[1], ~b[0]};
    endfunction

    always_comb
        Pinos = {pad_pins(pres[1], six[1], held[1], Select[1], nlow),
                 pad_pins(pres[0], six[0], held[0], Select[0], nlow)};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_frame();
        @(negedge Clock50);
        v_sync = 1'b1;
        lat = 0;
        while (lat < 200) begin
            @(negedge Clock50);
            lat++;
            if (Valid) break;
        end
        cap_saidas  = Saidas;
        cap_pressed = Pressed;
        cap_present = Present;
        cap_is6     = Is6;
        v_sync = 1'b0;
        repeat (5) @(negedge Clock50);
    endtask

    initial begin
        int valids, falls;
        logic prev_sel;
        held = '0;
        held[0] = 12'h011;

        repeat (3) @(negedge Clock50);
        check("rst_select",  32'(Select),  32'h3);
        check("rst_saidas",  32'(Saidas),  32'h0);
        check("rst_pressed", 32'(Pressed), 32'h0);
        check("rst_present", 32'(Present), 32'h0);
        check("rst_busy",    32'(Busy),    32'h0);
        check("rst_valid",   32'(Valid),   32'h0);
        Reset = 1'b0;
        repeat (3) @(negedge Clock50);

        // Frame 1: A+Up on pad0, pad1 absent
        run_frame();
        check("f1_latency", 32'(lat),         32'(LAT));
        check("f1_saidas",  32'(cap_saidas),  32'h000011);
        check("f1_present", 32'(cap_present), 32'h1);
        check("f1_pressed", 32'(cap_pressed), 32'h000011);
        check("f1_is6",     32'(cap_is6),     32'h0);
        check("f1_pulse",   32'(Pressed),     32'h0);

        // Frame 2: held, then release Up
        run_frame();
        check("f2_saidas",  32'(cap_saidas),  32'h000011);
        check("f2_pressed", 32'(cap_pressed), 32'h0);
        held[0] = 12'h010;
        run_frame();
        check("f3_saidas",  32'(cap_saidas),  32'h000010);
        check("f3_pressed", 32'(cap_pressed), 32'h0);

        // Six-button model X+Start on pad0, three-button B on pad1
        pres = 2'b11; six = 2'b01;
        held[0] = 12'h180; held[1] = 12'h020;
        run_frame();
        check("f4_latency", 32'(lat),         32'(LAT));
        check("f4_saidas",  32'(cap_saidas),  {8'h0, 12'h020, EXP_X_START});
        check("f4_pressed", 32'(cap_pressed), {8'h0, 12'h020, EXP_X_START});
        check("f4_is6",     32'(cap_is6),     32'(EXP_IS6));
        check("f4_present", 32'(cap_present), 32'h3);

        // v_sync rise during phase 1 must be ignored
        valids = 0; falls = 0;
        @(negedge Clock50);
        v_sync = 1'b1;
        prev_sel = Select[0];
        for (int i = 1; i <= 80; i++) begin
            @(negedge Clock50);
            if (Valid) valids++;
            if (prev_sel && !Select[0]) falls++;
            prev_sel = Select[0];
            if (i == 4)  v_sync = 1'b0;
            if (i == 8)  v_sync = 1'b1;
            if (i == 70) v_sync = 1'b0;
        end
        check("f5_valids",   32'(valids), 32'h1);
        check("f5_selfalls", 32'(falls),  32'(NPH / 2));
        check("f5_idle",     32'(Busy),   32'h0);
        check("f5_saidas",   32'(Saidas), {8'h0, 12'h020, EXP_X_START});
        repeat (5) @(negedge Clock50);

        // Reset in the middle of an odd phase
        @(negedge Clock50);
        v_sync = 1'b1;
        repeat (4 + 4 * RST_PH) @(negedge Clock50);
        check("f6_busy_pre",   32'(Busy),   32'h1);
        check("f6_select_pre", 32'(Select), 32'h0);
        Reset = 1'b1;
        @(negedge Clock50);
        check("f6_select", 32'(Select), 32'h3);
        check("f6_busy",   32'(Busy),   32'h0);
        check("f6_saidas", 32'(Saidas), 32'h0);
        check("f6_valid",  32'(Valid),  32'h0);
        Reset = 1'b0;
        v_sync = 1'b0;
        repeat (5) @(negedge Clock50);
        run_frame();
        check("f7_latency", 32'(lat),         32'(LAT));
        check("f7_saidas",  32'(cap_saidas),  {8'h0, 12'h020, EXP_X_START});
        check("f7_pressed", 32'(cap_pressed), {8'h0, 12'h020, EXP_X_START});

        // Unplug pad0
        pres = 2'b10;
        run_frame();
        check("f8_present", 32'(cap_present), 32'h2);
        check("f8_saidas",  32'(cap_saidas),  32'h020000);
        check("f8_pressed", 32'(cap_pressed), 32'h0);
        check("f8_is6",     32'(cap_is6),     32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
